udt_close_ctrl: RTL and testbench

//  Parametrised successor to the UDT close-packet sink, sitting between the control-packet demux and the connection state logic.

---
 rtl/udt_pkg.sv | 32 +++
 rtl/udt_close_ctrl_if.sv | 15 +
 rtl/udt_hdr_serializer.sv | 75 +++++++
 rtl/udt_close_ctrl.sv | 174 +++++++++++++++++
 tb/tb_udt_close_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udt_pkg.sv
// Shared UDT definitions for the close/shutdown path: control header
// constants, close-FSM state encoding and the SHUTDOWN header builder.
package udt_pkg;

    localparam int UDT_HDR_W = 128;

    // Bit 127 of a UDT header marks a control packet.
    localparam logic UDT_CTRL_BIT = 1'b1;

    // Control type field value for SHUTDOWN.
    localparam logic [14:0] UDT_CTRL_SHUTDOWN = 15'h0005;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_WAIT_SND = 3'd2,
        ST_WAIT_REV = 3'd3,
        ST_SEND     = 3'd4,
        ST_CLOSED   = 3'd5
    } close_state_e;

    // SHUTDOWN header: control bit, type, reserved, additional info,
    // timestamp, destination socket ID (MSB first).
    function automatic logic [UDT_HDR_W-1:0] shutdown_hdr(
        input logic [31:0] timestamp,
        input logic [31:0] dst_sock_id
    );
        return {UDT_CTRL_BIT, UDT_CTRL_SHUTDOWN, 16'h0000, 32'h0000_0000,
                timestamp, dst_sock_id};
    endfunction

endpackage

// File: rtl/udt_close_ctrl_if.sv
// AXI-Stream bundle used for both the inbound CLOSE stream and the
// outbound SHUTDOWN stream of udt_close_ctrl.
interface udt_close_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tready;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/udt_hdr_serializer.sv
// Serialises a 128-bit UDT header MSB-first into 128/DATA_W AXI-Stream
// beats. load_i captures the header and starts the burst; done_o pulses
// on the handshake of the final beat. All stream outputs come from flops.
module udt_hdr_serializer
    import udt_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load_i,
    input  logic [UDT_HDR_W-1:0] hdr_i,
    output logic                 tvalid_o,
    output logic [DATA_W-1:0]    tdata_o,
    output logic [KEEP_W-1:0]    tkeep_o,
    output logic                 tlast_o,
    input  logic                 tready_i,
    output logic                 done_o
);

    localparam int NBEATS = UDT_HDR_W / DATA_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

    logic [UDT_HDR_W-1:0] hdr_q, hdr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 handshake;

    assign handshake = valid_q && tready_i;

    // Load a new header, or advance to the next slice on each handshake.
    always_comb begin
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            hdr_d   = hdr_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (handshake) begin
            if (last_q) begin
                valid_d = 1'b0;
            end else begin
                hdr_d = hdr_q << DATA_W;
                cnt_d = cnt_q + 1'b1;
            end
        end
        last_d = valid_d && (cnt_d == LAST_IDX);
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            hdr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign tvalid_o = valid_q;
    assign tdata_o  = hdr_q[UDT_HDR_W-1 -: DATA_W];
    assign tkeep_o  = {KEEP_W{valid_q}};
    assign tlast_o  = last_q;
    assign done_o   = handshake && last_q;

endmodule

// File: rtl/udt_close_ctrl.sv
// UDT close controller: sinks one inbound CLOSE packet, waits for the send
// and receive buffers to drain, emits a SHUTDOWN control packet and then
// reports the connection closed until re-armed.
// Optional feature: define UDT_CLOSE_LINGER_EN to bound the time spent
// waiting for the send buffer (LINGER_CYCLES), flagged by linger_expired_o.
module udt_close_ctrl
    import udt_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
`ifdef UDT_CLOSE_LINGER_EN
    ,
    parameter int LINGER_W      = 24,
    parameter int LINGER_CYCLES = 1000000
`endif
) (
    input  logic                    core_clk,
    input  logic                    core_rst,
    udt_close_ctrl_if.slave         close_s,
    input  logic                    SND_BUFFER_EMPTY_i,
    input  logic                    REV_BUFFER_EMPTY_i,
    input  logic [31:0]             dst_sock_id_i,
    input  logic [31:0]             timestamp_i,
    udt_close_ctrl_if.master        shut_m,
    input  logic                    rearm_i,
    output logic                    close_busy_o,
    output logic                    conn_closed_o,
    output logic                    linger_expired_o
);

    close_state_e state_q, state_d;
    logic         tready_q, tready_d;
    logic         busy_q, busy_d;
    logic         closed_q, closed_d;
    logic         accept;
    logic         load;
    logic         linger_hit;
    logic         ser_done;

    logic              ser_tvalid;
    logic [DATA_W-1:0] ser_tdata;
    logic [KEEP_W-1:0] ser_tkeep;
    logic              ser_tlast;

    // Inbound payload content is irrelevant; only the framing matters.
    logic unused_ok;
    assign unused_ok = ^{close_s.tdata, close_s.tkeep};

    assign accept = close_s.tvalid && tready_q;

`ifdef UDT_CLOSE_LINGER_EN
    logic [LINGER_W-1:0] linger_cnt_q, linger_cnt_d;
    logic                expired_q, expired_d;

    assign linger_hit = (state_q == ST_WAIT_SND) && !SND_BUFFER_EMPTY_i &&
                        (linger_cnt_q == LINGER_W'(LINGER_CYCLES - 1));

    // Linger counter runs (saturating) only in WAIT_SND; sticky expiry flag.
    always_comb begin
        linger_cnt_d = '0;
        expired_d    = expired_q;
        if (state_q == ST_WAIT_SND) begin
            linger_cnt_d = (linger_cnt_q == '1) ? linger_cnt_q : linger_cnt_q + 1'b1;
        end
        if (linger_hit) begin
            expired_d = 1'b1;
        end else if (state_q == ST_CLOSED && rearm_i) begin
            expired_d = 1'b0;
        end
    end

    // Linger registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            linger_cnt_q <= '0;
            expired_q    <= 1'b0;
        end else begin
            linger_cnt_q <= linger_cnt_d;
            expired_q    <= expired_d;
        end
    end

    assign linger_expired_o = expired_q;
`else
    assign linger_hit       = 1'b0;
    assign linger_expired_o = 1'b0;
`endif

    // Close sequence next-state logic and registered output decode.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = close_s.tlast ? ST_WAIT_SND : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && close_s.tlast) begin
                    state_d = ST_WAIT_SND;
                end
            end
            ST_WAIT_SND: begin
                if (SND_BUFFER_EMPTY_i || linger_hit) begin
                    state_d = ST_WAIT_REV;
                end
            end
            ST_WAIT_REV: begin
                // Header fields are captured by the serializer on this edge.
                if (REV_BUFFER_EMPTY_i) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_d = ST_CLOSED;
                end
            end
            ST_CLOSED: begin
                if (rearm_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tready_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
        busy_d   = (state_d == ST_DRAIN) || (state_d == ST_WAIT_SND) ||
                   (state_d == ST_WAIT_REV) || (state_d == ST_SEND);
        closed_d = (state_d == ST_CLOSED);
    end

    // State and status registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q  <= ST_IDLE;
            tready_q <= 1'b1;
            busy_q   <= 1'b0;
            closed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            closed_q <= closed_d;
        end
    end

    udt_hdr_serializer #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_ser (
        .clk      (core_clk),
        .srst     (core_rst),
        .load_i   (load),
        .hdr_i    (shutdown_hdr(timestamp_i, dst_sock_id_i)),
        .tvalid_o (ser_tvalid),
        .tdata_o  (ser_tdata),
        .tkeep_o  (ser_tkeep),
        .tlast_o  (ser_tlast),
        .tready_i (shut_m.tready),
        .done_o   (ser_done)
    );

    assign close_s.tready = tready_q;
    assign shut_m.tvalid  = ser_tvalid;
    assign shut_m.tdata   = ser_tdata;
    assign shut_m.tkeep   = ser_tkeep;
    assign shut_m.tlast   = ser_tlast;
    assign close_busy_o   = busy_q;
    assign conn_closed_o  = closed_q;

endmodule

// File: tb/tb_udt_close_ctrl.sv
// Self-checking bench for udt_close_ctrl: a 64-bit instance driven through
// directed and randomized close sequences, plus a 128-bit instance for the
// single-beat SHUTDOWN case with toggling backpressure.
module tb_udt_close_ctrl;

    localparam int LCYC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        snd, rev, rearm;
    logic [31:0] sock, ts;
    logic        busy64, closed64, lexp64;
    logic        snd2, rev2, rearm2;
    logic [31:0] sock2, ts2;
    logic        busy128, closed128, lexp128;

    udt_close_ctrl_if #(.DATA_W(64))  c64  ();
    udt_close_ctrl_if #(.DATA_W(64))  s64  ();
    udt_close_ctrl_if #(.DATA_W(128)) c128 ();
    udt_close_ctrl_if #(.DATA_W(128)) s128 ();

    udt_close_ctrl #(
        .DATA_W (64)
`ifdef UDT_CLOSE_LINGER_EN
        , .LINGER_W (24), .LINGER_CYCLES (LCYC)
`endif
    ) u_dut64 (
        .core_clk (clk), .core_rst (rst), .close_s (c64.slave),
        .SND_BUFFER_EMPTY_i (snd), .REV_BUFFER_EMPTY_i (rev),
        .dst_sock_id_i (sock), .timestamp_i (ts), .shut_m (s64.master),
        .rearm_i (rearm), .close_busy_o (busy64), .conn_closed_o (closed64),
        .linger_expired_o (lexp64)
    );

    udt_close_ctrl #(
        .DATA_W (128)
`ifdef UDT_CLOSE_LINGER_EN
        , .LINGER_W (24), .LINGER_CYCLES (LCYC)
`endif
    ) u_dut128 (
        .core_clk (clk), .core_rst (rst), .close_s (c128.slave),
        .SND_BUFFER_EMPTY_i (snd2), .REV_BUFFER_EMPTY_i (rev2),
        .dst_sock_id_i (sock2), .timestamp_i (ts2), .shut_m (s128.master),
        .rearm_i (rearm2), .close_busy_o (busy128), .conn_closed_o (closed128),
        .linger_expired_o (lexp128)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference SHUTDOWN header straight from the packet format.
    function automatic logic [127:0] ref_hdr(input logic [31:0] s, input logic [31:0] t);
        logic [127:0] h;
        h = {1'b1, 15'h0005, 16'h0000, 32'h0, t, s};
        return h;
    endfunction

    task automatic chk_reset64(input string tag);
        chk({tag, "_in_tready"}, c64.tready, 1'b1);
        chk({tag, "_sh_valid"},  s64.tvalid, 1'b0);
        chk({tag, "_sh_data"},   s64.tdata,  64'h0);
        chk({tag, "_sh_keep"},   s64.tkeep,  8'h0);
        chk({tag, "_sh_last"},   s64.tlast,  1'b0);
        chk({tag, "_busy"},      busy64,     1'b0);
        chk({tag, "_closed"},    closed64,   1'b0);
        chk({tag, "_lexp"},      lexp64,     1'b0);
    endtask

    // One complete close on the 64-bit instance, checked cycle by cycle
    // against the timing rules: WAIT_SND and WAIT_REV each last at least
    // one cycle and end on the first sampled empty flag (or linger expiry).
    task automatic run_close64(input int nbeats, input int gap_pct, input int snd_delay,
                               input int rev_delay, input int rdy_pct,
                               input logic [31:0] s_val, input logic [31:0] t_val,
                               input bit rst_mid);
        logic [63:0]  q[$];
        logic [127:0] h;
        int idx, guard, t_snd, t_rev, exp_valid;
        bit exp_lexp;

        $display("close: beats=%0d snd_delay=%0d rev_delay=%0d rdy=%0d%% sock=%08h ts=%08h rst_mid=%0d",
                 nbeats, snd_delay, rev_delay, rdy_pct, s_val, t_val, rst_mid);
        sock = s_val;
        ts   = t_val;

        // Inbound CLOSE packet with random gaps; empties/rearm are noise here.
        idx = 0;
        guard = 0;
        while (idx < nbeats && guard < 1000) begin
            c64.tvalid = ($urandom_range(99) >= gap_pct);
            c64.tdata  = {$urandom, $urandom};
            c64.tkeep  = 8'($urandom);
            c64.tlast  = (idx == nbeats - 1);
            snd        = 1'($urandom);
            rev        = 1'($urandom);
            rearm      = 1'($urandom);
            chk("in_tready", c64.tready, 1'b1);
            chk("in_busy", busy64, idx > 0);
            if (c64.tvalid) idx++;
            step();
            guard++;
        end

        t_snd    = snd_delay + 1;
        exp_lexp = 1'b0;
`ifdef UDT_CLOSE_LINGER_EN
        if (snd_delay >= LCYC) begin
            t_snd    = LCYC;
            exp_lexp = 1'b1;
        end
`endif
        t_rev     = imax(t_snd + 1, rev_delay + 1);
        exp_valid = t_rev + 1;

        // Buffer wait: inbound stalled with a follow-on packet pending.
        for (int cyc = 1; cyc < exp_valid; cyc++) begin
            c64.tvalid = 1'b1;
            c64.tlast  = 1'($urandom);
            snd        = (cyc <= t_snd) ? (cyc > snd_delay) : 1'($urandom);
            rev        = (cyc > rev_delay);
            rearm      = 1'($urandom);
            s64.tready = 1'($urandom);
            chk("wait_in_tready", c64.tready, 1'b0);
            chk("wait_busy", busy64, 1'b1);
            chk("wait_sh_valid", s64.tvalid, 1'b0);
            step();
        end
        c64.tvalid = 1'b0;
        rearm      = 1'b0;

        h = ref_hdr(s_val, t_val);
        q.push_back(h[127:64]);
        q.push_back(h[63:0]);

        // SHUTDOWN beats under random backpressure.
        guard = 0;
        while (q.size() > 0 && guard < 300) begin
            sock       = $urandom;
            ts         = $urandom;
            s64.tready = ($urandom_range(99) < rdy_pct);
            chk("sh_valid", s64.tvalid, 1'b1);
            chk("sh_data", s64.tdata, q[0]);
            chk("sh_last", s64.tlast, q.size() == 1);
            chk("sh_keep", s64.tkeep, 8'hFF);
            chk("sh_busy", busy64, 1'b1);
            if (s64.tready) begin
                $display("  beat %016h last=%0d", q[0], q.size() == 1);
                void'(q.pop_front());
                if (rst_mid) begin
                    step();
                    s64.tready = 1'b0;
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    chk_reset64("midrst");
                    rearm = 1'b1;
                    step();
                    rearm = 1'b0;
                    chk_reset64("midrst_rearm");
                    return;
                end
            end
            step();
            guard++;
        end
        chk("sh_timeout_left", q.size(), 0);

        chk("done_sh_valid", s64.tvalid, 1'b0);
        chk("done_closed", closed64, 1'b1);
        chk("done_busy", busy64, 1'b0);
        chk("done_in_tready", c64.tready, 1'b0);
        chk("done_lexp", lexp64, exp_lexp);
        step();
        chk("hold_closed", closed64, 1'b1);

        rearm = 1'b1;
        step();
        rearm = 1'b0;
        chk("rearm_closed", closed64, 1'b0);
        chk("rearm_in_tready", c64.tready, 1'b1);
        chk("rearm_lexp", lexp64, 1'b0);
    endtask

    initial begin
        logic [127:0] h128;
        bit           tog, done;

        rst = 1'b1;
        snd = 1'b0; rev = 1'b0; rearm = 1'b0; sock = '0; ts = '0;
        c64.tvalid = 1'b0; c64.tdata = '0; c64.tkeep = '0; c64.tlast = 1'b0;
        s64.tready = 1'b0;
        snd2 = 1'b0; rev2 = 1'b0; rearm2 = 1'b0; sock2 = '0; ts2 = '0;
        c128.tvalid = 1'b0; c128.tdata = '0; c128.tkeep = '0; c128.tlast = 1'b0;
        s128.tready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset64("reset");
        chk("reset128_in_tready", c128.tready, 1'b1);
        chk("reset128_sh_valid", s128.tvalid, 1'b0);
        chk("reset128_closed", closed128, 1'b0);

        // Single-beat close, immediate empties, full throughput.
        run_close64(1, 0, 0, 0, 100, 32'h1234_5678, 32'h0000_00AA, 1'b0);
        // Four-beat close with gaps in tvalid.
        run_close64(4, 50, 0, 0, 100, $urandom, $urandom, 1'b0);
        // Send buffer stays busy for 50 cycles.
        run_close64(1, 0, 50, 0, 100, $urandom, $urandom, 1'b0);
        // Send buffer never drains in time (linger case when enabled).
        run_close64(2, 20, 40, 3, 70, $urandom, $urandom, 1'b0);
        // Reset in the middle of SEND, then a full re-run.
        run_close64(3, 30, 2, 5, 100, $urandom, $urandom, 1'b1);
        run_close64(2, 0, 0, 0, 100, $urandom, $urandom, 1'b0);
        // Randomized closes.
        for (int i = 0; i < 8; i++) begin
            run_close64($urandom_range(1, 6), $urandom_range(0, 60), $urandom_range(0, 20),
                        $urandom_range(0, 25), $urandom_range(30, 100), $urandom, $urandom, 1'b0);
        end

        // 128-bit instance: single SHUTDOWN beat, ready toggling each cycle.
        sock2 = $urandom;
        ts2   = $urandom;
        snd2  = 1'b1;
        rev2  = 1'b1;
        $display("close128: sock=%08h ts=%08h", sock2, ts2);
        h128 = ref_hdr(sock2, ts2);
        c128.tvalid = 1'b1;
        c128.tlast  = 1'b1;
        c128.tdata  = {$urandom, $urandom, $urandom, $urandom};
        c128.tkeep  = '1;
        chk("t4_in_tready", c128.tready, 1'b1);
        step();
        c128.tvalid = 1'b0;
        for (int cyc = 1; cyc < 3; cyc++) begin
            chk("t4_pre_valid", s128.tvalid, 1'b0);
            step();
        end
        tog  = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            sock2       = $urandom;
            ts2         = $urandom;
            s128.tready = tog;
            chk("t4_valid", s128.tvalid, 1'b1);
            chk("t4_data", s128.tdata, h128);
            chk("t4_last", s128.tlast, 1'b1);
            chk("t4_keep", s128.tkeep, 16'hFFFF);
            if (tog) begin
                $display("  beat128 %032h", s128.tdata);
                done = 1'b1;
            end
            tog = ~tog;
            step();
        end
        s128.tready = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_after_valid", s128.tvalid, 1'b0);
        chk("t4_closed", closed128, 1'b1);
        chk("t4_lexp", lexp128, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
